// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : Multi-channel switch debouncer with press/release pulses and
//                optional hold-to-auto-repeat pulses per channel.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_multi #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int REPEAT_CYCLES   = 2500000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Level,
    output logic [NUM_CH-1:0] o_Press,
    output logic [NUM_CH-1:0] o_Release,
    output logic [NUM_CH-1:0] o_Repeat
);

    localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int c_RP_W   = $clog2(c_RP_MAX) + 1;

    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RP_W-1:0] c_HOLD_LAST = c_RP_W'(HOLD_CYCLES - 1);
    localparam logic [c_RP_W-1:0] c_RPT_LAST  = c_RP_W'(REPEAT_CYCLES - 1);
    localparam logic              c_INV       = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic              r_sync1;
            logic              r_sync2;
            logic              r_level;
            logic              r_press;
            logic              r_release;
            logic [c_DB_W-1:0] r_db_cnt;
            logic              w_change;
            logic              w_rise;
            logic              w_fall;

            // Level flips on the edge where the disagreement run hits terminal count
            assign w_change = (r_sync2 != r_level) && (r_db_cnt == c_DB_LAST);
            assign w_rise   = w_change &&  r_sync2;
            assign w_fall   = w_change && !r_sync2;

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_L) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_db_cnt  <= '0;
                end else begin
                    r_sync1   <= i_Switch[g] ^ c_INV;
                    r_sync2   <= r_sync1;
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    if (r_sync2 == r_level) begin
                        r_db_cnt <= '0;
                    end else if (w_change) begin
                        r_level  <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign o_Level[g]   = r_level;
            assign o_Press[g]   = r_press;
            assign o_Release[g] = r_release;

            if (REPEAT_EN != 0) begin : g_rpt
                rpt_state_t        r_state;
                rpt_state_t        w_state_nxt;
                logic [c_RP_W-1:0] r_rp_cnt;
                logic [c_RP_W-1:0] w_rp_cnt_nxt;
                logic              r_repeat;
                logic              w_repeat_nxt;

                // Enter HOLD on the same edge o_Press is registered so the counter
                // is zero during the press cycle; a falling level overrides everything.
                always_comb begin
                    w_state_nxt  = r_state;
                    w_rp_cnt_nxt = r_rp_cnt + 1'b1;
                    w_repeat_nxt = 1'b0;
                    if (w_fall || (!r_level && !w_rise)) begin
                        w_state_nxt  = ST_IDLE;
                        w_rp_cnt_nxt = '0;
                    end else if (w_rise) begin
                        w_state_nxt  = ST_HOLD;
                        w_rp_cnt_nxt = '0;
                    end else begin
                        case (r_state)
                            ST_HOLD: begin
                                if (r_rp_cnt == c_HOLD_LAST) begin
                                    w_state_nxt  = ST_REPEAT;
                                    w_rp_cnt_nxt = '0;
                                    w_repeat_nxt = 1'b1;
                                end
                            end
                            ST_REPEAT: begin
                                if (r_rp_cnt == c_RPT_LAST) begin
                                    w_rp_cnt_nxt = '0;
                                    w_repeat_nxt = 1'b1;
                                end
                            end
                            default: begin
                                w_state_nxt  = ST_IDLE;
                                w_rp_cnt_nxt = '0;
                            end
                        endcase
                    end
                end

                always_ff @(posedge i_Clk) begin
                    if (!i_Rst_L) begin
                        r_state  <= ST_IDLE;
                        r_rp_cnt <= '0;
                        r_repeat <= 1'b0;
                    end else begin
                        r_state  <= w_state_nxt;
                        r_rp_cnt <= w_rp_cnt_nxt;
                        r_repeat <= w_repeat_nxt;
                    end
                end

                assign o_Repeat[g] = r_repeat;
            end else begin : g_no_rpt
                assign o_Repeat[g] = 1'b0;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_multi
//  Description : Scoreboard bench for debounce_multi (2 channels, short timers).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_multi;

    localparam int NUM_CH = 2;
    localparam int DB     = 4;

    logic              clk = 1'b0;
    logic              rst_l;
    logic [NUM_CH-1:0] sw;
    logic [NUM_CH-1:0] level, press, release_p, rpt;

    logic [31:0] cyc = 32'd0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [39:0] exp_q[$];

    debounce_multi #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1),
        .REPEAT_EN       (1),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (5)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_l),
        .i_Switch  (sw),
        .o_Level   (level),
        .o_Press   (press),
        .o_Release (release_p),
        .o_Repeat  (rpt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Event key: {cycle, kind(1=press,2=release,3=repeat), channel}
    function automatic logic [39:0] mk(input logic [31:0] cy, input int kind, input int ch);
        return {cy, 4'(kind), 4'(ch)};
    endfunction

    function automatic void push_exp(input logic [39:0] key);
        int i = 0;
        while (i < exp_q.size() && exp_q[i] < key) i++;
        exp_q.insert(i, key);
    endfunction

    task automatic wait_cyc(input logic [31:0] t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every observed pulse pops the next expected event
    always @(negedge clk) begin
        if (cyc >= 32'd1) begin
            while (exp_q.size() > 0 && exp_q[0][39:8] < cyc)
                check_eq("missed_event", 40'd0, exp_q.pop_front());
            for (int k = 1; k <= 3; k++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    logic [NUM_CH-1:0] v;
                    v = (k == 1) ? press : (k == 2) ? release_p : rpt;
                    if (v[c] === 1'b1) begin
                        if (exp_q.size() == 0) check_eq("unexpected_event", mk(cyc, k, c), 40'd0);
                        else                   check_eq("event", mk(cyc, k, c), exp_q.pop_front());
                    end
                end
            end
        end
    end

    logic [31:0] n, p;

    initial begin
        rst_l = 1'b0;
        sw    = 2'b11;
        wait_cyc(2);
        check_eq("reset_level",   40'(level),     40'd0);
        check_eq("reset_pulses",  40'({press, release_p, rpt}), 40'd0);
        wait_cyc(3);
        rst_l = 1'b1;
        wait_cyc(4);
        check_eq("post_reset_level", 40'(level), 40'd0);

        // Single press with auto-repeat, released between repeats
        wait_cyc(8);
        n = cyc; sw[0] = 1'b0; p = n + DB + 2;
        push_exp(mk(p, 1, 0));
        for (int k = 10; k <= 40; k += 5) push_exp(mk(p + k, 3, 0));
        wait_cyc(p);
        check_eq("t1_level0", 40'(level[0]), 40'd1);
        check_eq("t1_level1", 40'(level[1]), 40'd0);
        check_eq("t1_press",  40'(press),    40'd1);
        wait_cyc(p + 36);
        sw[0] = 1'b1; push_exp(mk(p + 42, 2, 0));
        wait_cyc(p + 50);
        check_eq("t1_level_after", 40'(level), 40'd0);

        // Release coinciding with the first repeat terminal count
        n = cyc; sw[0] = 1'b0; p = n + DB + 2;
        push_exp(mk(p, 1, 0));
        wait_cyc(p + 4);
        sw[0] = 1'b1; push_exp(mk(p + 10, 2, 0));
        wait_cyc(p + 10);
        check_eq("t2_release", 40'(release_p), 40'd1);
        check_eq("t2_repeat",  40'(rpt),       40'd0);
        wait_cyc(p + 20);
        check_eq("t2_level_after", 40'(level), 40'd0);

        // Short glitches never reach the output
        for (int k = 0; k < 5; k++) begin
            sw[0] = 1'b0;
            repeat (3) @(negedge clk);
            sw[0] = 1'b1;
            repeat (3) @(negedge clk);
            check_eq("t3_glitch_level", 40'(level), 40'd0);
        end
        repeat (6) @(negedge clk);
        check_eq("t3_final_level", 40'(level), 40'd0);

        // Both channels pressed together, released independently
        n = cyc; sw = 2'b00; p = n + DB + 2;
        push_exp(mk(p, 1, 0));
        push_exp(mk(p, 1, 1));
        wait_cyc(p);
        check_eq("t4_press_both", 40'(press), 40'd3);
        wait_cyc(p + 2);
        sw[0] = 1'b1; push_exp(mk(p + 8, 2, 0));
        wait_cyc(p + 5);
        sw[1] = 1'b1; push_exp(mk(p + 11, 2, 1));
        push_exp(mk(p + 10, 3, 1));
        wait_cyc(p + 9);
        check_eq("t4_level_mid", 40'(level), 40'd2);
        wait_cyc(p + 20);
        check_eq("t4_level_after", 40'(level), 40'd0);

        // Reset mid-debounce with switch held
        n = cyc; sw[0] = 1'b0;
        wait_cyc(n + 4);
        rst_l = 1'b0;
        wait_cyc(n + 5);
        check_eq("t5_reset_outputs", 40'({level, press, release_p, rpt}), 40'd0);
        rst_l = 1'b1;
        p = n + 5 + DB + 2;
        push_exp(mk(p, 1, 0));
        wait_cyc(p - 1);
        check_eq("t5_level_before", 40'(level), 40'd0);
        wait_cyc(p);
        check_eq("t5_level_press", 40'(level), 40'd1);
        wait_cyc(p + 2);
        sw[0] = 1'b1; push_exp(mk(p + 8, 2, 0));
        wait_cyc(p + 20);
        check_eq("t5_level_after", 40'(level), 40'd0);

        while (exp_q.size() > 0) check_eq("missed_event", 40'd0, exp_q.pop_front());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
